// File: rtl/ironisland_pkg.sv
// Shared types and default parameters for the uio frame transmitter.
// The optional checksum byte is controlled by the FRAME_TX_CSUM_EN macro.
package ironisland_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        STB  = 2'd2,
        REL  = 2'd3
    } state_t;

    typedef logic [7:0] byte_t;

    localparam int DEF_MAX_LEN     = 8;
    localparam int DEF_ACK_TIMEOUT = 255;

endpackage

// File: rtl/ironisland_sync2.sv
// Two-flop synchronizer for a single asynchronous level input.
// Latency: 2 cycles; output resets to 0.
module ironisland_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/ironisland_uio_frame_tx.sv
// Buffers one frame from the core, then sends header/payload(/checksum) on uio pins
// with a four-phase strobe/ack handshake; checksum byte added when FRAME_TX_CSUM_EN is defined.
module ironisland_uio_frame_tx
    import ironisland_pkg::*;
#(
    parameter int MAX_LEN     = DEF_MAX_LEN,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       tx_ready,
    input  logic       host_ack,
    output logic       tx_stb,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    output logic       done,
    output logic       err
);

    localparam int CW = $clog2(MAX_LEN + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
`ifdef FRAME_TX_CSUM_EN
    localparam logic [8:0] TRAILER = 9'd1;
`else
    localparam logic [8:0] TRAILER = 9'd0;
`endif

    state_t          state_d, state_q;
    byte_t           buf_d [MAX_LEN];
    byte_t           buf_q [MAX_LEN];
    logic [CW-1:0]   wcnt_d, wcnt_q;
    byte_t           len_d, len_q;
    logic [8:0]      k_d, k_q;
    logic [TW-1:0]   tmo_d, tmo_q;
    logic            stb_d, stb_q;
    byte_t           out_d, out_q;
    logic            oe_d, oe_q;
    logic            done_d, done_q;
    logic            err_d, err_q;
`ifdef FRAME_TX_CSUM_EN
    byte_t           sum_d, sum_q;
`endif

    logic            ack_s;
    logic            xfer;
    logic            frame_end;
    logic            tmo_hit;
    logic            abort;
    logic [8:0]      kn;
    logic [8:0]      last_k;
    byte_t           nxt_byte;
    byte_t           first_len;

    ironisland_sync2 u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (host_ack),
        .q   (ack_s)
    );

    assign tx_ready  = (state_q == IDLE) || (state_q == FILL);
    assign xfer      = tx_valid && tx_ready;
    assign frame_end = tx_last || (wcnt_q == CW'(MAX_LEN - 1));
    assign first_len = byte_t'(wcnt_q) + 8'd1;
    assign tmo_hit   = (tmo_q == TW'(ACK_TIMEOUT - 1));
    assign kn        = k_q + 9'd1;
    assign last_k    = {1'b0, len_q} + TRAILER;

    // Byte shown on the pins once the current strobe is released: payload or checksum.
    always_comb begin
`ifdef FRAME_TX_CSUM_EN
        nxt_byte = sum_q + len_q;
`else
        nxt_byte = 8'h00;
`endif
        for (int i = 0; i < MAX_LEN; i++) begin
            if (kn == 9'(i + 1)) begin
                nxt_byte = buf_q[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        wcnt_d  = wcnt_q;
        len_d   = len_q;
        k_d     = k_q;
        tmo_d   = tmo_q;
        stb_d   = stb_q;
        out_d   = out_q;
        oe_d    = oe_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        abort   = 1'b0;
`ifdef FRAME_TX_CSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            IDLE, FILL: begin
                if (xfer) begin
                    for (int i = 0; i < MAX_LEN; i++) begin
                        if (wcnt_q == CW'(i)) begin
                            buf_d[i] = tx_data;
                        end
                    end
`ifdef FRAME_TX_CSUM_EN
                    sum_d = ((state_q == IDLE) ? 8'h00 : sum_q) + tx_data;
`endif
                    if (frame_end) begin
                        state_d = STB;
                        len_d   = first_len;
                        out_d   = first_len;
                        stb_d   = 1'b1;
                        oe_d    = 1'b1;
                        k_d     = 9'd0;
                        tmo_d   = '0;
                        wcnt_d  = '0;
                    end else begin
                        state_d = FILL;
                        wcnt_d  = wcnt_q + 1'b1;
                    end
                end
            end
            STB: begin
                if (ack_s) begin
                    state_d = REL;
                    stb_d   = 1'b0;
                    tmo_d   = '0;
                    // Present the following byte now so it is settled well before the next strobe.
                    if (k_q != last_k) begin
                        out_d = nxt_byte;
                    end
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            REL: begin
                if (!ack_s) begin
                    tmo_d = '0;
                    if (k_q == last_k) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        oe_d    = 1'b0;
                    end else begin
                        state_d = STB;
                        stb_d   = 1'b1;
                        k_d     = kn;
                    end
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (abort) begin
            state_d = IDLE;
            err_d   = 1'b1;
            stb_d   = 1'b0;
            oe_d    = 1'b0;
            wcnt_d  = '0;
            tmo_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            buf_q   <= '{default: '0};
            wcnt_q  <= '0;
            len_q   <= '0;
            k_q     <= '0;
            tmo_q   <= '0;
            stb_q   <= 1'b0;
            out_q   <= '0;
            oe_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef FRAME_TX_CSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            wcnt_q  <= wcnt_d;
            len_q   <= len_d;
            k_q     <= k_d;
            tmo_q   <= tmo_d;
            stb_q   <= stb_d;
            out_q   <= out_d;
            oe_q    <= oe_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef FRAME_TX_CSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    assign tx_stb  = stb_q;
    assign uio_out = out_q;
    assign uio_oe  = oe_q ? 8'hFF : 8'h00;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_ironisland_uio_frame_tx.sv
// Scoreboard bench: stimulus queues expected pin bytes and frame outcomes, a monitor
// pops them on every strobe rise and every done/err pulse; a host model drives host_ack.
module tb_ironisland_uio_frame_tx;

`ifdef FRAME_TX_CSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif
    localparam int MAXL = 8;
    localparam int TMO  = 255;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_ready;
    logic       host_ack;
    logic       tx_stb;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       done;
    logic       err;

    ironisland_uio_frame_tx #(.MAX_LEN(MAXL), .ACK_TIMEOUT(TMO)) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_last  (tx_last),
        .tx_ready (tx_ready),
        .host_ack (host_ack),
        .tx_stb   (tx_stb),
        .uio_out  (uio_out),
        .uio_oe   (uio_oe),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [7:0] exp_bytes[$];
    int         exp_end[$];     // 0 = done, 1 = timeout in STB, 2 = timeout in REL
    logic [7:0] fb[$];
    int  ack_mode  = 0;         // 0 = prompt host, 1 = never acks, 2 = slow ack release
    int  rel_delay = 0;
    bit  host_busy = 1'b0;
    int  strobes   = 0;
    int  ends_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Host side of the handshake.
    initial begin
        host_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_stb) begin
                host_busy = 1'b1;
                if (ack_mode == 1) begin
                    while (tx_stb) @(negedge clk);
                end else begin
                    repeat ($urandom_range(0, 4)) @(negedge clk);
                    host_ack = 1'b1;
                    while (tx_stb) @(negedge clk);
                    if (ack_mode == 2) repeat (rel_delay) @(negedge clk);
                    else repeat ($urandom_range(0, 4)) @(negedge clk);
                    host_ack = 1'b0;
                end
                host_busy = 1'b0;
            end
        end
    end

    // Monitor.
    initial begin
        logic prev_stb;
        int   rise_cyc, fall_cyc, kind;
        logic [7:0] e;
        prev_stb = 1'b0;
        rise_cyc = 0;
        fall_cyc = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (done || err) begin
                    ends_seen++;
                    check("end_expected", exp_end.size() > 0, 1);
                    kind = (exp_end.size() > 0) ? exp_end.pop_front() : 0;
                    check("end_is_err", err, kind != 0);
                    check("end_is_done", done, kind == 0);
                    check("end_bytes_left", exp_bytes.size(), 0);
                    check("end_oe", uio_oe, 8'h00);
                    check("end_stb", tx_stb, 0);
                    if (done) check("done_ready", tx_ready, 1);
                    if (err && kind == 1) check("tmo_stb_cycles", cyc - rise_cyc, TMO);
                    if (err && kind == 2) check("tmo_rel_cycles", cyc - fall_cyc, TMO);
                    exp_bytes.delete();
                end
                if (tx_stb && !prev_stb) begin
                    strobes++;
                    rise_cyc = cyc;
                    check("strobe_oe", uio_oe, 8'hFF);
                    check("strobe_expected", exp_bytes.size() > 0, 1);
                    if (exp_bytes.size() > 0) begin
                        e = exp_bytes.pop_front();
                        check("pin_byte", uio_out, e);
                    end
                end
                if (!tx_stb && prev_stb) fall_cyc = cyc;
            end
            prev_stb = tx_stb;
        end
    end

    task automatic wait_host_idle();
        int g = 0;
        while (host_busy && g < 2000) begin
            @(negedge clk);
            g++;
        end
        check("host_idle", host_busy, 0);
    endtask

    task automatic drive_bytes(input bit use_last);
        int g;
        for (int i = 0; i < fb.size(); i++) begin
            @(negedge clk);
            tx_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            tx_valid = 1'b1;
            tx_data  = fb[i];
            tx_last  = use_last && (i == fb.size() - 1);
            g = 0;
            while (!tx_ready && g < 2000) begin
                @(negedge clk);
                g++;
            end
            check("ready_for_byte", tx_ready, 1);
            @(posedge clk);
            if (i == fb.size() - 1) begin
                #1;
                check("ready_after_last", tx_ready, 0);
            end
        end
        @(negedge clk);
        tx_valid = 1'b0;
        tx_last  = 1'b0;
    endtask

    task automatic send_frame(input bit use_last, input int mode, input int rdelay, input int kind);
        int e0, g;
        logic [7:0] sum;
        wait_host_idle();
        ack_mode  = mode;
        rel_delay = rdelay;
        sum = 8'(fb.size());
        exp_bytes.push_back(8'(fb.size()));
        if (kind == 0) begin
            foreach (fb[i]) begin
                exp_bytes.push_back(fb[i]);
                sum = sum + fb[i];
            end
            if (CSUM) exp_bytes.push_back(sum);
        end
        exp_end.push_back(kind);
        e0 = ends_seen;
        drive_bytes(use_last);
        g = 0;
        while (ends_seen == e0 && g < 20000) begin
            @(posedge clk);
            g++;
        end
        check("frame_finished", ends_seen - e0, 1);
    endtask

    initial begin
        int n, s0, g;
        bit ul;
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tx_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_stb", tx_stb, 0);
        check("rst_out", uio_out, 8'h00);
        check("rst_oe", uio_oe, 8'h00);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready", tx_ready, 1);

        fb = '{8'hA1, 8'hB2, 8'hC3};
        send_frame(1'b1, 0, 0, 0);

        fb = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        send_frame(1'b0, 0, 0, 0);

        fb = '{8'h77};
        send_frame(1'b1, 1, 0, 1);
        fb = '{8'h5A, 8'h6B};
        send_frame(1'b1, 0, 0, 0);

        fb = '{8'h3C};
        send_frame(1'b1, 2, 200, 0);
        fb = '{8'h4D, 8'h4E};
        send_frame(1'b1, 2, 256, 2);

        // Reset in the middle of transmitting a frame.
        wait_host_idle();
        ack_mode = 0;
        fb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        exp_bytes.push_back(8'd5);
        foreach (fb[i]) exp_bytes.push_back(fb[i]);
        s0 = strobes;
        drive_bytes(1'b1);
        g = 0;
        while (strobes < s0 + 3 && g < 2000) begin
            @(negedge clk);
            g++;
        end
        check("mid_strobes", strobes - s0, 3);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_stb", tx_stb, 0);
        check("midrst_oe", uio_oe, 8'h00);
        check("midrst_ready", tx_ready, 1);
        exp_bytes.delete();
        exp_end.delete();
        @(negedge clk);
        rst = 1'b0;
        fb = '{8'h55};
        send_frame(1'b1, 0, 0, 0);

        for (int f = 0; f < 20; f++) begin
            n  = $urandom_range(1, MAXL);
            ul = (n < MAXL) ? 1'b1 : 1'($urandom_range(0, 1));
            fb.delete();
            for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
            send_frame(ul, 0, 0, 0);
        end

        fb = '{8'hA1};
        send_frame(1'b1, 0, 0, 0);

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ironisland_uio_frame_tx.md
# ironisland_uio_frame_tx

Frame transmitter that carries byte data from the chronospatial core out to the off-chip host over the bidirectional uio pins: the outbound direction of the host pin interface. It buffers one frame from the core, then sends length header, payload and an optional checksum using a four-phase strobe/ack handshake. It sits inside the Tiny Tapeout top between the core logic and uio_out/uio_oe, with strobe on a uo_out bit and ack on a ui_in bit.

## Interface
- MAX_LEN, 8: payload buffer depth in bytes (1..255).
- ACK_TIMEOUT, 255: cycles allowed per handshake phase before abort (≥4).
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tx_valid  in  1  core offers tx_data.
- tx_data  in  8  payload byte.
- tx_last  in  1  qualifies final payload byte of frame.
- tx_ready  out  1  block accepts a byte this cycle.
- host_ack  in  1  asynchronous ack from pin (ui_in bit).
- tx_stb  out  1  strobe to host (uo_out bit).
- uio_out  out  8  byte on pins.
- uio_oe  out  8  pin drive enable, 8'hFF while framing, else 8'h00.
- done  out  1  one-cycle pulse, frame sent.
- err  out  1  one-cycle pulse, frame aborted on timeout.

## Operation
- States: IDLE, FILL, STB (strobe high, wait ack high), REL (strobe low, wait ack low).
- tx_ready = 1 in IDLE and FILL, 0 in STB/REL; transfer on tx_valid & tx_ready.
- IDLE: first transfer stores byte 0, goes to FILL (or straight to STB if it ends the frame).
- Frame ends on a transfer with tx_last=1 or on the MAX_LEN-th byte (tx_last implied).
- Byte sequence index k: k=0 header = payload length len (1..MAX_LEN); k=1..len payload in order; k=len+1 checksum (macro only).
- STB: tx_stb=1, uio_out=byte k; on synced ack=1 go REL.
- REL: tx_stb=0, uio_out already shows byte k+1; on synced ack=0, k++ and go STB, or after last byte go IDLE with done pulse.
- host_ack passes a 2-flop synchronizer; only synced value used.
- Timeout counter clears on every STB/REL entry; reaching ACK_TIMEOUT: err pulse, tx_stb=0, uio_oe=0, buffer discarded, IDLE.
- Reset at any point: next edge all registers cleared, pins released, frame lost.

## Timing
- Reset values: tx_stb=0, uio_out=0, uio_oe=0, done=0, err=0, state IDLE; tx_ready=1 the first cycle after rst deasserts.
- Last transfer at edge N: edge N+1 enters STB, tx_stb=1, uio_oe=8'hFF, uio_out=len.
- host_ack rising at edge A: tx_stb falls at edge A+3 (2 sync + 1 decision); same for ack fall -> tx_stb rise.
- uio_out changes only on the edge tx_stb falls; stable ≥3 cycles before each strobe rise.
- done asserts the edge REL completes for final byte; same edge uio_oe=0, tx_ready=1.
- Back-to-back frames: new fill may start the cycle after done.

## Configuration
- FRAME_TX_CSUM_EN defined: checksum byte appended after payload, value = (header + all payload bytes) mod 256; frame is len+2 bytes.
- Undefined: no checksum byte, frame is len+1 bytes, adder absent.

## Structure
- Package ironisland_pkg: state enum (IDLE/FILL/STB/REL), 8-bit byte type, default MAX_LEN and ACK_TIMEOUT constants.
- One sub-module: ironisland_sync2 (2-flop synchronizer, reset to 0) for host_ack.
- Buffer is a flop array indexed by write count; no RAM macro.

## Test plan
- Frame 8'hA1,8'hB2,8'hC3 (tx_last on C3), host acks in 5 cycles -> pins 8'h03,A1,B2,C3,8'h19 (csum), done once, uio_oe back to 0.
- 8 bytes 8'h01..8'h08 without tx_last, MAX_LEN=8 -> tx_ready drops after 8th, header 8'h08, csum 8'h2C.
- Host never acks -> err at ACK_TIMEOUT (255) cycles after strobe rise, uio_oe=0, tx_stb=0, next frame sends cleanly.
- Ack fall delayed 200 cycles then released -> no err, frame completes; delayed 256 -> err in REL.
- rst asserted mid-payload -> next edge tx_stb=0, uio_oe=0, tx_ready=1; following frame 8'h55 sends 8'h01,55,56.
- Build without FRAME_TX_CSUM_EN, frame 8'hA1 -> exactly 2 strobes (8'h01, A1) then done.
